// File: rtl/gpio_debounce_pkg.sv
// Shared board-I/O header.
// Holds the default debounce timing constants and a clog2 helper that never
// returns less than 1, so counters sized from it always have at least one bit.
package gpio_debounce_pkg;

    localparam int unsigned DEFAULT_TICK_DIV     = 1000;
    localparam int unsigned DEFAULT_STABLE_TICKS = 16;

    // Ceiling log2 with a floor of 1 bit, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// Single-channel synchroniser and debouncer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_din       - raw asynchronous pin level
//   i_tick      - one-clk debounce sample strobe from the shared prescaler
//   o_level     - debounced level
//   o_rise      - one-clk pulse, registered, coincident with level going 0->1
//   o_fall      - one-clk pulse, registered, coincident with level going 1->0
module gpio_debounce_ch
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    input  logic i_tick,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned      CNT_W    = clog2(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    logic [CNT_W-1:0] w_cnt_d;
    logic             w_level_d;
    logic             w_rise_d;
    logic             w_fall_d;

    always_comb begin
        w_cnt_d   = r_cnt;
        w_level_d = r_level;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;
        if (i_tick) begin
            if (r_s2 == r_level) begin
                // Any agreeing sample restarts the stability run.
                w_cnt_d = '0;
            end else if (r_cnt == CNT_LAST) begin
                w_level_d = r_s2;
                w_cnt_d   = '0;
                w_rise_d  = r_s2;
                w_fall_d  = ~r_s2;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_din;
            r_s2    <= r_s1;
            r_cnt   <= w_cnt_d;
            r_level <= w_level_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_debounce.sv
// Multi-channel GPIO input debouncer with sticky edge-event register.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_din        - WIDTH raw asynchronous pin levels
//   o_level      - debounced levels
//   o_rise       - one-clk rising-edge pulses
//   o_fall       - one-clk falling-edge pulses
//   o_evt        - sticky OR of rise|fall since the last acknowledge
//   o_evt_valid  - high whenever o_evt is non-zero
//   i_evt_ack    - clears o_evt; edges arriving in the same clk stay set
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_evt,
    output logic             o_evt_valid,
    input  logic             i_evt_ack
);

    localparam int unsigned       PRESC_W    = clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_d;
    logic               w_tick;

    logic [WIDTH-1:0]   r_evt;
    logic [WIDTH-1:0]   w_evt_d;
    logic [WIDTH-1:0]   w_level;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;

    assign w_tick = (r_presc == PRESC_LAST);

    always_comb begin
        w_presc_d = r_presc + 1'b1;
        if (w_tick) begin
            w_presc_d = '0;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        gpio_debounce_ch #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_din   (i_din[g]),
            .i_tick  (w_tick),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    // New edges are OR'd in after the ack mask so a simultaneous edge is kept.
    always_comb begin
        w_evt_d = (r_evt & ~{WIDTH{i_evt_ack}}) | w_rise | w_fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_evt   <= '0;
        end else begin
            r_presc <= w_presc_d;
            r_evt   <= w_evt_d;
        end
    end

    assign o_level     = w_level;
    assign o_rise      = w_rise;
    assign o_fall      = w_fall;
    assign o_evt       = r_evt;
    assign o_evt_valid = |r_evt;

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Input-side counterpart to the board's LED/GPIO output driver. It samples up to WIDTH asynchronous board inputs (DIP switches, push buttons, GPIO header pins), synchronises and debounces each one, and reports clean levels. It also reports one-cycle rise/fall pulses and a sticky event register that software or a controlling FSM reads and clears via a valid/ack handshake.

## Interface
- WIDTH, 8: number of input channels.
- TICK_DIV, 1000: clk cycles per debounce sample tick (≥ 2).
- STABLE_TICKS, 16: consecutive differing samples required to accept a new level (≥ 1).

- clk  input  1  system clock. One clock domain.
- rst_n  input  1  reset, asynchronous assert, active-low.
- din  input  WIDTH  raw asynchronous pin levels.
- level  output  WIDTH  debounced level.
- rise  output  WIDTH  one-clk pulse when level goes 0→1.
- fall  output  WIDTH  one-clk pulse when level goes 1→0.
- evt  output  WIDTH  sticky OR of rise|fall since last ack.
- evt_valid  output  1  high when evt != 0.
- evt_ack  input  1  clears evt; sampled on clk.

## Operation
- Synchroniser: two flops per channel (s1, s2), reset 0. s2 is the only consumer of din.
- Prescaler: free-running counter 0..TICK_DIV-1, wraps to 0. tick=1 for the one clk where the counter equals TICK_DIV-1.
- Per channel, on tick only:
  - s2 == level: cnt ← 0.
  - s2 != level and cnt == STABLE_TICKS-1: level ← s2, cnt ← 0, rise or fall asserted for this clk.
  - s2 != level otherwise: cnt ← cnt+1.
- Off tick: cnt and level hold; rise and fall are 0.
- cnt width is clog2(STABLE_TICKS), minimum 1. The counter never exceeds STABLE_TICKS-1.
- Event register: evt_next = (evt & ~{WIDTH{evt_ack}}) | rise | fall. A new edge in the same clk as evt_ack stays set. Ack with evt == 0 has no effect.
- evt_valid is combinational from the evt register.

## Timing
- Reset values: level=0, rise=0, fall=0, evt=0, evt_valid=0, cnt=0, prescaler=0, s1/s2=0.
- After reset release, a channel held at 1 reports a rise once debounced. This is intended; the first read reflects power-up state.
- Latency from a din change (stable afterwards) to level/rise: 2 clk synchroniser, then up to TICK_DIV clk to the next tick, plus (STABLE_TICKS-1)·TICK_DIV clk.
  - Bounds: 2+(STABLE_TICKS-1)·TICK_DIV+1 to 2+STABLE_TICKS·TICK_DIV clk.
- rise/fall are registered and coincide with the first clk in which level shows the new value.
- evt updates one clk after rise/fall. evt_valid follows evt in the same clk.
- A glitch shorter than one tick period that is not sampled on a tick is invisible. A sampled glitch resets nothing by itself, but any matching sample clears cnt.
- Simultaneous edges on several channels: all are reported in the same clk and OR'd into evt.
- Reset mid-debounce: all state clears immediately. There is no partial carry-over.

## Structure
- Shared header: clog2 function and default TICK_DIV/STABLE_TICKS constants, reused by other board-I/O blocks.
- Sub-module debounce_ch: one per channel, generated WIDTH times. It holds s1, s2, cnt, level and the rise/fall flops, with tick as an input.
- Top level holds the prescaler and the event register.

## Test plan
All scenarios use TICK_DIV=4, STABLE_TICKS=3, WIDTH=8.
- Reset: rst_n low with din=8'hFF → all outputs 0. Release → level=8'hFF with rise=8'hFF pulsed once, within 14 clk.
- Clean step: din[0] 0→1 and held → rise[0] one clk wide, between 11 and 14 clk later. level[0]=1 in that same clk. evt[0]=1 and evt_valid=1 on the next clk.
- Bounce: toggle din[1] every 8 clk for 64 clk, then hold 0 → rise[1]=fall[1]=0 throughout and level[1] stays 0.
- Handshake: evt=8'h01, pulse evt_ack for 1 clk → evt=0 and evt_valid=0 on the next clk. evt_ack held with no edges → evt stays 0.
- Ack collision: evt=8'h01 and a fall[2] pulse arrive in the same clk as evt_ack → next evt=8'h04.
- Mid-debounce reset: din[3] 0→1, assert rst_n low after 6 clk, release with din[3]=1 → no rise[3] before release. rise[3] follows a full latency of 11–14 clk after release.
